// File: rtl/conv1d_kernel_scheduler.sv
// conv1d_kernel_scheduler: sequences NUM_KERNELS filter passes over one
// input buffer and one MAC unit (loop order: kernel, output, tap).
// Ports: clk, rst (async, active-high), start/busy/done host handshake,
// out_ready write backpressure, kernel_id, w_addr/x_addr/out_addr buffer
// addresses, clear/valid/write MAC and output-buffer strobes.
module conv1d_kernel_scheduler #(
    parameter int KERNEL_SIZE   = 3,
    parameter int STRIDE        = 1,
    parameter int INPUT_SIZE    = 27,
    parameter int NUM_KERNELS   = 4,
    parameter int W_ADDR_BITS   = 4,
    parameter int X_ADDR_BITS   = 5,
    parameter int OUT_ADDR_BITS = 7,
    localparam int OUTPUT_SIZE  = (INPUT_SIZE - KERNEL_SIZE) / STRIDE + 1,
    localparam int KID_BITS     = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic [KID_BITS-1:0]      kernel_id,
    output logic [W_ADDR_BITS-1:0]   w_addr,
    output logic [X_ADDR_BITS-1:0]   x_addr,
    output logic [OUT_ADDR_BITS-1:0] out_addr,
    output logic                     clear,
    output logic                     valid,
    output logic                     write
);

    localparam int O_BITS = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int T_BITS = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MAC,
        VALID,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [O_BITS-1:0] o_cnt;
    logic [T_BITS-1:0] t_cnt;

    // Address arithmetic is done at 32 bits and truncated on assignment.
    logic [31:0] k_base;
    logic [31:0] o_base;
    logic [31:0] tap_next;
    logic [31:0] out_idx;
    logic        last_tap;
    logic        last_out;
    logic        last_kernel;

    assign k_base      = 32'(kernel_id) * 32'(KERNEL_SIZE);
    assign o_base      = 32'(o_cnt) * 32'(STRIDE);
    assign tap_next    = 32'(t_cnt) + 32'd1;
    assign out_idx     = 32'(kernel_id) * 32'(OUTPUT_SIZE) + 32'(o_cnt);
    assign last_tap    = (32'(t_cnt) == 32'(KERNEL_SIZE - 1));
    assign last_out    = (32'(o_cnt) == 32'(OUTPUT_SIZE - 1));
    assign last_kernel = (32'(kernel_id) == 32'(NUM_KERNELS - 1));

    // Outputs are registered and are loaded on the edge that enters the
    // state they belong to, so they always describe the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            clear     <= 1'b0;
            valid     <= 1'b0;
            write     <= 1'b0;
            kernel_id <= '0;
            w_addr    <= '0;
            x_addr    <= '0;
            out_addr  <= '0;
            o_cnt     <= '0;
            t_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        clear     <= 1'b1;
                        kernel_id <= '0;
                        o_cnt     <= '0;
                        t_cnt     <= '0;
                    end
                end
                CLEAR: begin
                    state  <= MAC;
                    clear  <= 1'b0;
                    t_cnt  <= '0;
                    w_addr <= W_ADDR_BITS'(k_base);
                    x_addr <= X_ADDR_BITS'(o_base);
                end
                MAC: begin
                    if (last_tap) begin
                        state    <= VALID;
                        valid    <= 1'b1;
                        out_addr <= OUT_ADDR_BITS'(out_idx);
                    end else begin
                        t_cnt  <= t_cnt + 1'b1;
                        w_addr <= W_ADDR_BITS'(k_base + tap_next);
                        x_addr <= X_ADDR_BITS'(o_base + tap_next);
                    end
                end
                VALID: begin
                    state <= WRITE;
                    valid <= 1'b0;
                    write <= 1'b1;
                end
                WRITE: begin
                    // write and out_addr hold until the buffer accepts.
                    if (out_ready) begin
                        write <= 1'b0;
                        if (!last_out) begin
                            o_cnt <= o_cnt + 1'b1;
                            state <= CLEAR;
                            clear <= 1'b1;
                        end else if (!last_kernel) begin
                            kernel_id <= kernel_id + 1'b1;
                            o_cnt     <= '0;
                            state     <= CLEAR;
                            clear     <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    clear <= 1'b0;
                    valid <= 1'b0;
                    write <= 1'b0;
                end
            endcase
        end
    end

endmodule
